neuron_mac_acc: RTL and testbench

//  Sequential fixed-point multiply-accumulate for one neuron of the digit-detection network.

---
 rtl/neuron_mac_acc_if.sv | 25 ++
 rtl/neuron_mac_acc.sv | 142 ++++++++++++++
 tb/tb_neuron_mac_acc.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_acc_if.sv
// Stream bundle for one neuron MAC: start/bias, pixel/weight input pairs, result handshake and status.
// master drives start, bias, pairs and out_ready; slave returns ready, result and status.
interface neuron_mac_acc_if;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pix;
  logic [31:0] wgt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic        overflow;

  modport master (
    output start, bias, in_valid, pix, wgt, out_ready,
    input  in_ready, out_valid, result, busy, overflow
  );

  modport slave (
    input  start, bias, in_valid, pix, wgt, out_ready,
    output in_ready, out_valid, result, busy, overflow
  );
endinterface

// File: rtl/neuron_mac_acc.sv
// Q17.14 multiply-accumulate for one neuron: bias plus N_INPUTS pixel*weight products, one pair per cycle.
// Result is valid one cycle after the last accepted pair. Define ACC_SAT_EN to saturate instead of wrapping.
module fa_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module neuron_mac_acc #(
  parameter int N_INPUTS = 784
) (
  input  logic           clk,
  input  logic           rst_n,
  neuron_mac_acc_if.slave bus
);
  localparam int FRAC_W = 14;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state;
  logic [31:0]        acc;
  logic [31:0]        prod_reg;
  logic               prod_vld;
  logic [CNT_W-1:0]   count;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        result_r;
  logic               busy_r;
  logic               ovf_r;

  logic signed [63:0] p64;
  logic signed [63:0] p_sh;
  logic               prod_ovf;
  logic [31:0]        prod_nxt;
  logic [31:0]        sum;
  logic               sum_cout;
  logic               acc_ovf;
  logic [31:0]        acc_nxt;
  logic               accept;
  logic               last;

  always_comb begin
    p64      = $signed(bus.pix) * $signed(bus.wgt);
    p_sh     = p64 >>> FRAC_W;
    // Product fits in 32 bits only when p64[63:45] is a pure sign extension.
    prod_ovf = ~((&p_sh[63:31]) | ~(|p_sh[63:31]));
`ifdef ACC_SAT_EN
    prod_nxt = prod_ovf ? (p64[63] ? 32'h8000_0000 : 32'h7FFF_FFFF) : p_sh[31:0];
`else
    prod_nxt = p_sh[31:0];
`endif
  end

  fa_32b u_add (
    .a     (acc),
    .b     (prod_reg),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (sum_cout)
  );

  always_comb begin
    // Carry into the MSB differs from carry out exactly when same-sign operands flip the sum sign.
    acc_ovf = sum_cout ^ (acc[31] ^ prod_reg[31] ^ sum[31]);
`ifdef ACC_SAT_EN
    acc_nxt = acc_ovf ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
    acc_nxt = sum;
`endif
  end

  assign accept = bus.in_valid & in_ready_r;
  assign last   = accept && (count == CNT_W'(N_INPUTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      prod_reg    <= '0;
      prod_vld    <= 1'b0;
      count       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      busy_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod_reg <= prod_nxt;
        count    <= count + 1'b1;
        if (prod_ovf) ovf_r <= 1'b1;
      end
      if (prod_vld) begin
        acc <= acc_nxt;
        if (acc_ovf) ovf_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc        <= bus.bias;
            count      <= '0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (last) begin
            in_ready_r <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          result_r    <= acc_nxt;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;
  assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_neuron_mac_acc.sv
// Bench for neuron_mac_acc with two pairs per neuron: directed cases plus random neurons against a
// plain-arithmetic model (honours ACC_SAT_EN when defined).
module tb_neuron_mac_acc;
  localparam int N = 2;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] pa [N];
  logic [31:0] wa [N];

  neuron_mac_acc_if bus ();

  neuron_mac_acc #(.N_INPUTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic longint fit32(input longint v, output bit ovf);
    longint maxv = 64'sd2147483647;
    longint minv = -64'sd2147483648;
    ovf = (v > maxv) || (v < minv);
`ifdef ACC_SAT_EN
    if (v > maxv) return maxv;
    if (v < minv) return minv;
    return v;
`else
    return longint'($signed(v[31:0]));
`endif
  endfunction

  function automatic void model(input logic [31:0] b, output logic [31:0] r, output logic o);
    longint a;
    longint pr;
    longint fixed;
    bit     ov;
    a = longint'($signed(b));
    o = 1'b0;
    for (int i = 0; i < N; i++) begin
      pr = (longint'($signed(pa[i])) * longint'($signed(wa[i]))) >>> 14;
      pr = fit32(pr, ov);
      o  = o | ov;
      a  = fit32(a + pr, ov);
      o  = o | ov;
    end
    fixed = a;
    r = fixed[31:0];
  endfunction

  task automatic feed(input logic [31:0] p, input logic [31:0] w, input bit gap);
    bit got;
    int n;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.pix = p;
    bus.wgt = w;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      got = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 20);
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_neuron(input logic [31:0] b, input bit stall, input int hold,
                            output logic [31:0] r, output logic o);
    bus.start = 1'b1;
    bus.bias  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < N; i++) feed(pa[i], wa[i], stall);
    chk("out_valid_drain", 32'(bus.out_valid), 32'd0);
    chk("in_ready_drain", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("out_valid_rise", 32'(bus.out_valid), 32'd1);
    r = bus.result;
    o = bus.overflow;
    for (int k = 0; k < hold; k++) begin
      bus.start = (k == 1);
      bus.bias  = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.result, r);
      chk("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.start     = (hold > 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("out_valid_fall", 32'(bus.out_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("result_keep", bus.result, r);
    @(posedge clk); #1;
    chk("still_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_basic();
    pa[0] = 32'h0000_8000; wa[0] = 32'h0000_C000;
    pa[1] = 32'hFFFF_C000; wa[1] = 32'h0000_2000;
  endtask

  function automatic logic [31:0] rnd_val();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = int'($urandom_range(0, 262144)) - 131072;
    return 32'(v);
  endfunction

  initial begin
    logic [31:0] r, er;
    logic        o, eo;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.bias = '0; bus.in_valid = 1'b0;
    bus.pix = '0; bus.wgt = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_basic();
    run_neuron(32'h0000_4000, 1'b0, 0, r, o);
    chk("basic_result", r, 32'h0001_A000);
    chk("basic_ovf", 32'(o), 32'd0);

    run_neuron(32'h0000_4000, 1'b1, 0, r, o);
    chk("stall_result", r, 32'h0001_A000);

    run_neuron(32'h0000_4000, 1'b0, 5, r, o);
    chk("bp_result", r, 32'h0001_A000);

    pa[0] = 32'h0000_4000; wa[0] = 32'h0000_4000;
    pa[1] = 32'h0;         wa[1] = 32'h0;
    run_neuron(32'h7FFF_C000, 1'b0, 0, r, o);
`ifdef ACC_SAT_EN
    chk("accovf_result", r, 32'h7FFF_FFFF);
`else
    chk("accovf_result", r, 32'h8000_0000);
`endif
    chk("accovf_flag", 32'(o), 32'd1);

    pa[0] = 32'h0000_0001; wa[0] = 32'h0000_0001;
    pa[1] = 32'hFFFF_FFFF; wa[1] = 32'h0000_0001;
    run_neuron(32'h0, 1'b0, 0, r, o);
    chk("trunc_result", r, 32'hFFFF_FFFF);
    chk("trunc_ovf", 32'(o), 32'd0);

    // Abort after one overflowing pair; reset must clear everything at once.
    bus.start = 1'b1; bus.bias = 32'h0000_4000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_basic();
    run_neuron(32'h0000_4000, 1'b0, 0, r, o);
    chk("post_rst_result", r, 32'h0001_A000);

    for (int t = 0; t < 30; t++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 4) == 0) ? $urandom : rnd_val();
      for (int i = 0; i < N; i++) begin
        pa[i] = rnd_val();
        wa[i] = rnd_val();
      end
      model(b, er, eo);
      run_neuron(b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), r, o);
      chk("rand_result", r, er);
      chk("rand_ovf", 32'(o), 32'(eo));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
